stage2_block_unpack: RTL and testbench
======================================

STAGE2_BLOCK_UNPACK -- requirements
Module: stage2_block_unpack

Interface
REQ-001 The module SHALL have the parameter LEN_35, default 42: byte length of a message of type `block_size_35.
REQ-002 The module SHALL have the parameter LEN_22, default 30: byte length of a `block_size_22 message.
REQ-003 The module SHALL have the parameter LEN_21, default 28: byte length of a `block_size_21 message.
REQ-004 The module SHALL have the parameter LEN_12, default 20: byte length of a `block_size_12 message.
REQ-005 The module SHALL have the parameter LEN_NONE, default 8: byte length of a message of any other type code.
REQ-006 The module SHALL use one clock; reset SHALL be asynchronous and active-low. Port list, clock and reset first:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream byte valid.
- in_ready  output  1  upstream byte accepted when in_valid and in_ready are both 1.
- in_data  input  8  block byte stream.
- in_last  input  1  upstream marks the final byte of the block.
- out_valid  output  1  output byte valid.
- out_ready  input  1  downstream accepts the output byte.
- out_data  output  8  registered copy of the accepted byte.
- out_sop  output  1  output byte is the first byte of a message.
- out_eop  output  1  output byte is the last byte of a message.
- out_msg_idx  output  2  message index within the block: 0, 1 or 2.
- out_msg_type  output  `block_size_control_width  type code of the current message.
- blk_done  output  1  one-cycle pulse at block completion.
- blk_size  output  `block_size_data_bits  total byte count of the last completed block.
- blk_err  output  1  one-cycle pulse on a framing error.

Function
REQ-007 A block SHALL consist of exactly three back-to-back messages (index 0, 1, 2); the first byte of each message SHALL carry the type code in bits [`block_size_control_width-1:0].
REQ-008 A single output register stage SHALL be used; in_ready SHALL equal (!out_valid || out_ready).
REQ-009 An accepted byte SHALL appear on out_data, with its sop, eop, idx and type, in the next cycle, giving 1-cycle latency.
REQ-010 The output byte SHALL be held stable while out_valid=1 and out_ready=0.
REQ-011 The FSM SHALL have the states HDR (awaiting the first byte of a message) and BODY (inside a message); reset state is HDR with message index 0.
REQ-012 In HDR, an accepted byte SHALL:
- set sop=1;
- decode the type and latch it into out_msg_type;
- load remaining = LEN(type) - 1;
- move to BODY. If LEN(type)=1, eop SHALL also be set and the FSM SHALL stay in HDR.
REQ-013 In BODY, each accepted byte SHALL decrement remaining. The byte accepted when remaining=1 SHALL get eop=1, and the FSM SHALL return to HDR with the index advanced by one, wrapping from 2 to 0.
REQ-014 The block size accumulator SHALL add LEN(type) at each header byte. It is `block_size_data_bits wide, with no saturation; the default maximum of 126 fits in 7 bits.
REQ-015 On acceptance of the eop byte of message 2, the following cycle SHALL:
- pulse blk_done for exactly one cycle;
- latch blk_size with the accumulated sum;
- clear the accumulator.
REQ-016 If in_last=1 on any accepted byte other than the eop byte of message 2, the following cycle SHALL:
- pulse blk_err;
- forward that byte with eop=1;
- return to HDR with index 0;
- clear the accumulator;
- leave blk_done low and blk_size unchanged.
REQ-017 If the eop byte of message 2 is accepted with in_last=0, blk_done and blk_err SHALL both pulse in the same cycle; blk_size SHALL still be updated.
REQ-018 in_last SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-019 While rst_n=0, all of the following SHALL hold:
- out_valid=0, out_sop=0, out_eop=0, out_data=0;
- out_msg_idx=0, out_msg_type=0;
- blk_done=0, blk_err=0, blk_size=0;
- FSM in HDR, accumulator 0;
- in_ready=1.
REQ-020 Reset asserted in the middle of a block SHALL discard that partial block. The first byte accepted after reset release SHALL be treated as the header of message 0.

Verification
REQ-021 Types 35/35/35 with 126 bytes, in_last on byte 126, out_ready=1 -> sop on output bytes 1, 43 and 85; eop on 42, 84 and 126; blk_done pulse; blk_size=126; blk_err=0.
REQ-022 Three messages of an unlisted type code (24 bytes) -> messages of 8 bytes each; blk_size=24.
REQ-023 Types 22/12/21 with out_ready toggling 1,0 every cycle -> in_ready follows the equation in REQ-008; no byte is lost or duplicated; blk_size=78.
REQ-024 Types 35/35/35 with in_last on byte 50 -> blk_err pulse; byte 50 output with eop=1; no blk_done; blk_size keeps its previous value; the next byte is decoded as the message 0 header.
REQ-025 Types 12/12/12 with no in_last -> blk_done and blk_err pulse together; blk_size=60.
REQ-026 rst_n pulsed low after byte 30 of a block, then a full 35/22/21 block is sent -> all outputs at their reset values during reset; blk_size=100.

Source files
------------

// File: rtl/stage2_block_unpack.sv
// Splits a byte stream into blocks of three typed messages and tags each byte
// with sop/eop/index/type through a single registered output stage.
`ifndef BLOCK_SIZE_CONTROL_WIDTH
`define BLOCK_SIZE_CONTROL_WIDTH 6
`endif
`ifndef BLOCK_SIZE_DATA_BITS
`define BLOCK_SIZE_DATA_BITS 8
`endif

module stage2_block_unpack #(
    parameter int LEN_35   = 42,
    parameter int LEN_22   = 30,
    parameter int LEN_21   = 28,
    parameter int LEN_12   = 20,
    parameter int LEN_NONE = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [7:0]                           in_data,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [7:0]                           out_data,
    output logic                                 out_sop,
    output logic                                 out_eop,
    output logic [1:0]                           out_msg_idx,
    output logic [`BLOCK_SIZE_CONTROL_WIDTH-1:0] out_msg_type,
    output logic                                 blk_done,
    output logic [`BLOCK_SIZE_DATA_BITS-1:0]     blk_size,
    output logic                                 blk_err
);
    localparam int CW = `BLOCK_SIZE_CONTROL_WIDTH;
    localparam int DW = `BLOCK_SIZE_DATA_BITS;

    typedef enum logic {HDR, BODY} state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_sop_q, out_sop_d;
    logic            out_eop_q, out_eop_d;
    logic [1:0]      out_idx_q, out_idx_d;
    logic [CW-1:0]   out_type_q, out_type_d;
    logic            blk_done_q, blk_done_d;
    logic            blk_err_q, blk_err_d;
    logic [DW-1:0]   blk_size_q, blk_size_d;

    logic            accept;
    logic            msg_end;
    logic [DW-1:0]   hdr_len;
    logic [DW-1:0]   sum;

    function automatic logic [DW-1:0] msg_len(input logic [CW-1:0] t);
        case (t)
            CW'(35): return DW'(LEN_35);
            CW'(22): return DW'(LEN_22);
            CW'(21): return DW'(LEN_21);
            CW'(12): return DW'(LEN_12);
            default: return DW'(LEN_NONE);
        endcase
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_idx_d   = out_idx_q;
        out_type_d  = out_type_q;
        blk_done_d  = 1'b0;
        blk_err_d   = 1'b0;
        blk_size_d  = blk_size_q;
        hdr_len     = msg_len(in_data[CW-1:0]);
        msg_end     = 1'b0;
        sum         = acc_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_idx_d   = idx_q;
            if (state_q == HDR) begin
                out_sop_d  = 1'b1;
                out_type_d = in_data[CW-1:0];
                sum        = acc_q + hdr_len;
                rem_d      = hdr_len - DW'(1);
                msg_end    = (hdr_len == DW'(1));
                state_d    = msg_end ? HDR : BODY;
            end else begin
                out_sop_d = 1'b0;
                rem_d     = rem_q - DW'(1);
                msg_end   = (rem_q == DW'(1));
                if (msg_end) state_d = HDR;
            end
            out_eop_d = msg_end;
            acc_d     = sum;

            // Block end wins over in_last; a missing in_last there is still flagged.
            if (msg_end && idx_q == 2'd2) begin
                blk_done_d = 1'b1;
                blk_size_d = sum;
                blk_err_d  = !in_last;
                acc_d      = '0;
                idx_d      = 2'd0;
                state_d    = HDR;
            end else if (in_last) begin
                blk_err_d = 1'b1;
                out_eop_d = 1'b1;
                acc_d     = '0;
                idx_d     = 2'd0;
                state_d   = HDR;
            end else if (msg_end) begin
                idx_d = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HDR;
            idx_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_idx_q   <= '0;
            out_type_q  <= '0;
            blk_done_q  <= 1'b0;
            blk_err_q   <= 1'b0;
            blk_size_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_idx_q   <= out_idx_d;
            out_type_q  <= out_type_d;
            blk_done_q  <= blk_done_d;
            blk_err_q   <= blk_err_d;
            blk_size_q  <= blk_size_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_sop      = out_sop_q;
    assign out_eop      = out_eop_q;
    assign out_msg_idx  = out_idx_q;
    assign out_msg_type = out_type_q;
    assign blk_done     = blk_done_q;
    assign blk_err      = blk_err_q;
    assign blk_size     = blk_size_q;

endmodule

// File: tb/tb_stage2_block_unpack.sv
// Directed bench for stage2_block_unpack: a message-level model predicts every
// output byte and block event, plus literal expectations per scenario.
module tb_stage2_block_unpack;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic [1:0] out_msg_idx;
    logic [5:0] out_msg_type;
    logic       blk_done;
    logic [7:0] blk_size;
    logic       blk_err;

    stage2_block_unpack dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_msg_idx(out_msg_idx),
        .out_msg_type(out_msg_type), .blk_done(blk_done), .blk_size(blk_size),
        .blk_err(blk_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        bit sop, eop, done, err;
        int idx, typ, size;
    } exp_t;

    exp_t expq[$];
    int   m_pos = 0, m_idx = 0, m_len = 0, m_typ = 0, m_sum = 0;
    int   done_cnt, err_cnt, out_cnt;
    int   sop_pos[$], eop_pos[$];
    int   pat = 0;

    function automatic int len_of(input int t);
        case (t)
            35: return 42;
            22: return 30;
            21: return 28;
            12: return 20;
            default: return 8;
        endcase
    endfunction

    task automatic model_clear();
        m_pos = 0; m_idx = 0; m_sum = 0;
    endtask

    task automatic model_push(input logic [7:0] d, input bit last);
        exp_t e;
        if (m_pos == 0) begin
            m_typ = d % 64;
            m_len = len_of(m_typ);
            m_sum += m_len;
        end
        e.d = d; e.sop = (m_pos == 0); e.eop = (m_pos == m_len - 1);
        e.idx = m_idx; e.typ = m_typ; e.done = 0; e.err = 0; e.size = 0;
        if (e.eop && m_idx == 2) begin
            e.done = 1; e.size = m_sum; e.err = !last; model_clear();
        end else if (last) begin
            e.err = 1; e.eop = 1; model_clear();
        end else if (e.eop) begin
            m_idx++; m_pos = 0;
        end else begin
            m_pos++;
        end
        expq.push_back(e);
    endtask

    // Compare process: one new output per acceptance in the previous cycle.
    bit         acc_prev = 0, v_prev = 0, r_prev = 0;
    logic [7:0] d_prev = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outs", {out_valid, out_sop, out_eop, out_data, out_msg_idx,
                                 out_msg_type, blk_done, blk_err, blk_size}, 0);
            check("reset_in_ready", in_ready, 1);
            acc_prev = 0; v_prev = 0; r_prev = 0;
        end else begin
            check("in_ready_eq", in_ready, !out_valid || out_ready);
            if (blk_done) done_cnt++;
            if (blk_err) err_cnt++;
            if (acc_prev) begin
                if (expq.size() == 0) begin
                    check("unexpected_byte", out_data, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    out_cnt++;
                    if (out_sop) sop_pos.push_back(out_cnt);
                    if (out_eop) eop_pos.push_back(out_cnt);
                    check("out_valid", out_valid, 1);
                    check("out_data", out_data, e.d);
                    check("out_sop", out_sop, e.sop);
                    check("out_eop", out_eop, e.eop);
                    check("out_msg_idx", out_msg_idx, e.idx);
                    check("out_msg_type", out_msg_type, e.typ);
                    check("blk_done", blk_done, e.done);
                    check("blk_err", blk_err, e.err);
                    if (e.done) check("blk_size", blk_size, e.size);
                end
            end else begin
                check("no_done_pulse", blk_done, 0);
                check("no_err_pulse", blk_err, 0);
                if (v_prev && !r_prev) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, d_prev);
                end
            end
            acc_prev = in_valid && in_ready;
            v_prev = out_valid; r_prev = out_ready; d_prev = out_data;
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit last, input bit tog);
        bit acc = 0;
        in_valid = 1; in_data = d; in_last = last;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (tog) out_ready = ~out_ready;
        end
        if (!acc) check("accept_timeout", 0, 1);
        else model_push(d, last);
    endtask

    task automatic send_block(input int t0, input int t1, input int t2,
                              input int nsend, input int last_at, input bit tog);
        int types[3];
        int n = 0;
        types[0] = t0; types[1] = t1; types[2] = t2;
        for (int m = 0; m < 3; m++) begin
            for (int b = 0; b < len_of(types[m]); b++) begin
                logic [7:0] d;
                if (n >= nsend) break;
                n++;
                d = (b == 0) ? 8'(types[m]) : 8'((pat * 37 + 11) & 8'hFF);
                pat++;
                send_byte(d, (n == last_at), tog);
            end
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0; in_last = 0; out_ready = 1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_test();
        done_cnt = 0; err_cnt = 0; out_cnt = 0;
        sop_pos.delete(); eop_pos.delete();
    endtask

    initial begin
        start_test();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        idle(2);

        // 35/35/35, in_last on byte 126
        start_test();
        send_block(35, 35, 35, 126, 126, 0);
        idle(4);
        check("t1_sop_count", sop_pos.size(), 3);
        check("t1_sop0", sop_pos[0], 1);
        check("t1_sop1", sop_pos[1], 43);
        check("t1_sop2", sop_pos[2], 85);
        check("t1_eop0", eop_pos[0], 42);
        check("t1_eop1", eop_pos[1], 84);
        check("t1_eop2", eop_pos[2], 126);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_blk_size", blk_size, 126);

        // unlisted type code: three 8-byte messages
        start_test();
        send_block(5, 5, 5, 24, 24, 0);
        idle(4);
        check("t2_eop1", eop_pos[1], 16);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_blk_size", blk_size, 24);

        // 22/12/21 with out_ready toggling
        start_test();
        out_ready = 1;
        send_block(22, 12, 21, 78, 78, 1);
        idle(4);
        check("t3_out_cnt", out_cnt, 78);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_blk_size", blk_size, 78);

        // early in_last on byte 50
        start_test();
        send_block(35, 35, 35, 50, 50, 0);
        idle(4);
        check("t4_eop_at_50", eop_pos[1], 50);
        check("t4_err_cnt", err_cnt, 1);
        check("t4_done_cnt", done_cnt, 0);
        check("t4_blk_size_kept", blk_size, 78);

        // 12/12/12 without in_last; header after the error is message 0
        start_test();
        send_block(12, 12, 12, 60, 0, 0);
        idle(4);
        check("t5_first_sop", sop_pos[0], 1);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_err_cnt", err_cnt, 1);
        check("t5_blk_size", blk_size, 60);

        // reset mid-block, then a full 35/22/21 block
        start_test();
        send_block(35, 22, 21, 30, 0, 0);
        rst_n = 0;
        expq.delete();
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        start_test();
        send_block(35, 22, 21, 100, 100, 0);
        idle(4);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_err_cnt", err_cnt, 0);
        check("t6_blk_size", blk_size, 100);

        check("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
